// File: rtl/cam_client_ctrl.sv
// cam_client_ctrl: initiator-side controller for a 2**IDX_W-entry CAM.
// Takes one read/write/search command at a time and returns one response.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   cmd_*                 valid/ready command channel (op, index, data)
//   rsp_*                 valid/ready response channel (op, hit, index, data, err)
//   cam_*_o               one-cycle CAM read/write/search strobes with index/data
//   cam_*_i               CAM read value/valid and search hit/index
//   stat_hits_o/misses_o  saturating search hit/miss counters
//                         (present only when CAM_CTRL_STATS_EN is defined)
module cam_client_ctrl #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 5,
  parameter int CAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [IDX_W-1:0]  cmd_index_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_op_o,
  output logic              rsp_hit_o,
  output logic [IDX_W-1:0]  rsp_index_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              cam_read_enable_o,
  output logic [IDX_W-1:0]  cam_read_index_o,
  output logic              cam_write_enable_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_search_enable_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_read_valid_i,
  input  logic [DATA_W-1:0] cam_read_value_i,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_hits_o,
  output logic [15:0]       stat_misses_o
`endif
);

  localparam int CNT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_SR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state               <= IDLE;
      op_q                <= '0;
      idx_q               <= '0;
      data_q              <= '0;
      cnt                 <= '0;
      cmd_ready_o         <= 1'b0;
      rsp_valid_o         <= 1'b0;
      rsp_op_o            <= '0;
      rsp_hit_o           <= 1'b0;
      rsp_index_o         <= '0;
      rsp_data_o          <= '0;
      rsp_err_o           <= 1'b0;
      cam_read_enable_o   <= 1'b0;
      cam_read_index_o    <= '0;
      cam_write_enable_o  <= 1'b0;
      cam_write_index_o   <= '0;
      cam_write_data_o    <= '0;
      cam_search_enable_o <= 1'b0;
      cam_search_data_o   <= '0;
`ifdef CAM_CTRL_STATS_EN
      stat_hits_o         <= '0;
      stat_misses_o       <= '0;
`endif
    end else begin
      // CAM strobes and buses are only non-zero for the single ISSUE cycle
      cam_read_enable_o   <= 1'b0;
      cam_read_index_o    <= '0;
      cam_write_enable_o  <= 1'b0;
      cam_write_index_o   <= '0;
      cam_write_data_o    <= '0;
      cam_search_enable_o <= 1'b0;
      cam_search_data_o   <= '0;

      unique case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            op_q        <= cmd_op_i;
            idx_q       <= cmd_index_i;
            data_q      <= cmd_data_i;
            unique case (cmd_op_i)
              OP_RD: begin
                cam_read_enable_o <= 1'b1;
                cam_read_index_o  <= cmd_index_i;
                state             <= ISSUE;
              end
              OP_WR: begin
                cam_write_enable_o <= 1'b1;
                cam_write_index_o  <= cmd_index_i;
                cam_write_data_o   <= cmd_data_i;
                state              <= ISSUE;
              end
              OP_SR: begin
                cam_search_enable_o <= 1'b1;
                cam_search_data_o   <= cmd_data_i;
                state               <= ISSUE;
              end
              default: begin
                // reserved op: answer with an error, never touch the CAM
                state       <= RESP;
                rsp_valid_o <= 1'b1;
                rsp_op_o    <= cmd_op_i;
                rsp_hit_o   <= 1'b0;
                rsp_err_o   <= 1'b1;
                rsp_index_o <= cmd_index_i;
                rsp_data_o  <= cmd_data_i;
              end
            endcase
          end
        end

        ISSUE: begin
          if (op_q == OP_WR) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_op_o    <= op_q;
            rsp_hit_o   <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_index_o <= idx_q;
            rsp_data_o  <= data_q;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(CAM_LAT - 1);
          end
        end

        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_op_o    <= op_q;
            rsp_err_o   <= 1'b0;
            if (op_q == OP_RD) begin
              rsp_hit_o   <= cam_read_valid_i;
              rsp_index_o <= idx_q;
              rsp_data_o  <= cam_read_value_i;
            end else begin
              rsp_hit_o   <= cam_search_valid_i;
              rsp_index_o <= cam_search_valid_i ? cam_search_index_i : '0;
              rsp_data_o  <= data_q;
`ifdef CAM_CTRL_STATS_EN
              if (cam_search_valid_i) begin
                if (stat_hits_o != 16'hFFFF)
                  stat_hits_o <= stat_hits_o + 16'd1;
              end else begin
                if (stat_misses_o != 16'hFFFF)
                  stat_misses_o <= stat_misses_o + 16'd1;
              end
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_op_o    <= '0;
            rsp_hit_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_index_o <= '0;
            rsp_data_o  <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_client_ctrl.sv
// tb_cam_client_ctrl: scoreboard bench for cam_client_ctrl.
// Two instances (CAM_LAT=1 and CAM_LAT=3) share a behavioural CAM model.
module tb_cam_client_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        cam_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_index;
  logic [31:0] cmd_data;
  logic        rsp_ready;

  logic        rdy1, rv1, rhit1, rerr1, re1, we1, se1;
  logic [1:0]  rop1;
  logic [4:0]  ridx1, ri1, wi1, csi1;
  logic [31:0] rdat1, wd1, sd1, crval1;
  logic        crv1, csv1;

  logic        rdy3, rv3, rhit3, rerr3, re3, we3, se3;
  logic [1:0]  rop3;
  logic [4:0]  ridx3, ri3, wi3, csi3;
  logic [31:0] rdat3, wd3, sd3, crval3;
  logic        crv3, csv3;

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] h1, m1, h3, m3;
`endif

  cam_client_ctrl #(.DATA_W(32), .IDX_W(5), .CAM_LAT(1)) u_dut1 (
`ifdef CAM_CTRL_STATS_EN
    .stat_hits_o(h1), .stat_misses_o(m1),
`endif
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(rdy1),
    .cmd_op_i(cmd_op), .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready & ~sel),
    .rsp_op_o(rop1), .rsp_hit_o(rhit1), .rsp_index_o(ridx1),
    .rsp_data_o(rdat1), .rsp_err_o(rerr1),
    .cam_read_enable_o(re1), .cam_read_index_o(ri1),
    .cam_write_enable_o(we1), .cam_write_index_o(wi1),
    .cam_write_data_o(wd1),
    .cam_search_enable_o(se1), .cam_search_data_o(sd1),
    .cam_read_valid_i(crv1), .cam_read_value_i(crval1),
    .cam_search_valid_i(csv1), .cam_search_index_i(csi1)
  );

  cam_client_ctrl #(.DATA_W(32), .IDX_W(5), .CAM_LAT(3)) u_dut3 (
`ifdef CAM_CTRL_STATS_EN
    .stat_hits_o(h3), .stat_misses_o(m3),
`endif
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(rdy3),
    .cmd_op_i(cmd_op), .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready & sel),
    .rsp_op_o(rop3), .rsp_hit_o(rhit3), .rsp_index_o(ridx3),
    .rsp_data_o(rdat3), .rsp_err_o(rerr3),
    .cam_read_enable_o(re3), .cam_read_index_o(ri3),
    .cam_write_enable_o(we3), .cam_write_index_o(wi3),
    .cam_write_data_o(wd3),
    .cam_search_enable_o(se3), .cam_search_data_o(sd3),
    .cam_read_valid_i(crv3), .cam_read_value_i(crval3),
    .cam_search_valid_i(csv3), .cam_search_index_i(csi3)
  );

  // selected-instance view
  logic        rdy, rv, rhit, rerr, cre, cwe, cse;
  logic [1:0]  rop;
  logic [4:0]  ridx, cri, cwi;
  logic [31:0] rdat, cwd, csd;
  assign rdy  = sel ? rdy3  : rdy1;
  assign rv   = sel ? rv3   : rv1;
  assign rhit = sel ? rhit3 : rhit1;
  assign rerr = sel ? rerr3 : rerr1;
  assign rop  = sel ? rop3  : rop1;
  assign ridx = sel ? ridx3 : ridx1;
  assign rdat = sel ? rdat3 : rdat1;
  assign cre  = sel ? re3   : re1;
  assign cwe  = sel ? we3   : we1;
  assign cse  = sel ? se3   : se1;
  assign cri  = sel ? ri3   : ri1;
  assign cwi  = sel ? wi3   : wi1;
  assign cwd  = sel ? wd3   : wd1;
  assign csd  = sel ? sd3   : sd1;

  // behavioural CAM: {read_valid, read_value, search_valid, search_index}
  logic [31:0] mem [32];
  logic        vld [32];
  logic [38:0] p1;
  logic [38:0] p3 [3];

  function automatic logic [38:0] cam_eval(
    input logic re, input logic [4:0] ri,
    input logic se, input logic [31:0] sd);
    logic [38:0] r;
    r = '0;
    if (re) r[38:6] = {vld[ri], mem[ri]};
    if (se)
      for (int i = 31; i >= 0; i--)
        if (vld[i] && mem[i] == sd) r[5:0] = {1'b1, 5'(i)};
    return r;
  endfunction

  always @(posedge clk) begin
    if (cam_clr) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
        vld[i] <= 1'b0;
      end
    end else if (we1 | we3) begin
      mem[we1 ? wi1 : wi3] <= we1 ? wd1 : wd3;
      vld[we1 ? wi1 : wi3] <= 1'b1;
    end
    p1    <= cam_eval(re1, ri1, se1, sd1);
    p3[0] <= cam_eval(re3, ri3, se3, sd3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign {crv1, crval1, csv1, csi1} = p1;
  assign {crv3, crval3, csv3, csi3} = p3[2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        hit;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] idx,
                        input logic [31:0] data, input logic e_hit,
                        input logic [4:0] e_idx, input logic [31:0] e_data,
                        input int hold);
    exp_t e;
    int n;
    logic [2:0] es;
    e.op   = op;
    e.hit  = e_hit;
    e.idx  = e_idx;
    e.data = e_data;
    e.err  = (op == 2'b11);
    e.lat  = (op == 2'b00 || op == 2'b10) ? 1 + (sel ? 3 : 1) : 1;
    sb.push_back(e);
    case (op)
      2'b00:   es = 3'b100;
      2'b01:   es = 3'b010;
      2'b10:   es = 3'b001;
      default: es = 3'b000;
    endcase
    cmd_op    = op;
    cmd_index = idx;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("strobe", 64'({cre, cwe, cse}), 64'(es));
    if (op == 2'b00) chk("rd_idx", 64'(cri), 64'(idx));
    if (op == 2'b01) chk("wr_idx_data", {cwi, cwd}, {idx, data});
    if (op == 2'b10) chk("sr_key", 64'(csd), 64'(data));
    chk("busy", 64'(rdy), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1)
        chk("strobe_off", {cre, cwe, cse, cri, cwi, cwd | csd}, 64'd0);
    end while (!rv && n < 20);
    e = sb.pop_front();
    chk("latency", 64'(n), 64'(e.lat));
    chk("rsp_op", 64'(rop), 64'(e.op));
    chk("rsp_hit", 64'(rhit), 64'(e.hit));
    chk("rsp_err", 64'(rerr), 64'(e.err));
    if (!e.err) begin
      chk("rsp_idx", 64'(ridx), 64'(e.idx));
      chk("rsp_data", 64'(rdat), 64'(e.data));
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rv), 64'd1);
      chk("hold_rsp", {rop, rhit, ridx, rdat}, {e.op, e.hit, e.idx, e.data});
      chk("hold_rdy", 64'(rdy), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", 64'(rv), 64'd0);
    chk("ready_back", 64'(rdy), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel       = 1'b0;
    cam_clr   = 1'b1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_index = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    cam_clr = 1'b0;
    chk("rst_out1", {rdy1, rv1, rop1, rhit1, ridx1, rdat1, rerr1},
        64'd0);
    chk("rst_cam1", {re1, we1, se1, ri1, wi1, wd1 | sd1}, 64'd0);
    chk("rst_out3", {rdy3, rv3, rerr3, re3, we3, se3}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", 64'(rdy1), 64'd1);
    chk("no_strobe", 64'({re1, we1, se1}), 64'd0);

    // CAM_LAT=1 instance
    do_cmd(2'b01, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    do_cmd(2'b00, 5'd5, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    do_cmd(2'b10, 5'd7, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    do_cmd(2'b10, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0, 0);
    do_cmd(2'b00, 5'd12, 32'h0, 1'b0, 5'd12, 32'h0, 0);
    do_cmd(2'b01, 5'd20, 32'hA5A5A5A5, 1'b1, 5'd20, 32'hA5A5A5A5, 10);
    do_cmd(2'b11, 5'd3, 32'h1234, 1'b0, 5'd3, 32'h1234, 0);

    // reset while a read sits in WAIT: no response may appear
    cmd_op    = 2'b00;
    cmd_index = 5'd5;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstw_rv", 64'(rv1), 64'd0);
    chk("rstw_rdy", 64'(rdy1), 64'd0);
    chk("rstw_cam", 64'({re1, we1, se1}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_rdy_rel", 64'(rdy1), 64'd1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rstw_no_rsp", 64'(rv1), 64'd0);
    end

    // CAM_LAT=3 instance
    sel = 1'b1;
    do_cmd(2'b01, 5'd9, 32'h12345678, 1'b1, 5'd9, 32'h12345678, 0);
    do_cmd(2'b10, 5'd0, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    do_cmd(2'b10, 5'd0, 32'h12345678, 1'b1, 5'd9, 32'h12345678, 0);
    do_cmd(2'b10, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 32'hCAFEF00D, 0);
    do_cmd(2'b00, 5'd9, 32'h0, 1'b1, 5'd9, 32'h12345678, 3);
`ifdef CAM_CTRL_STATS_EN
    chk("stat_hits", 64'(h3), 64'd2);
    chk("stat_misses", 64'(m3), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
